// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer, the byte-wide instruction memory, IF/ID and the redirect source.
// The master modport is the sequencer side; the slave modport is the memory / pipeline side.
// Width parameter must match the ADDR_W of the fetch_sequencer it connects to.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              enable;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              fetch_fault;

  modport master (
    input  enable,
    output mem_addr,
    input  mem_rdata,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc,
    input  redirect_valid,
    input  redirect_target,
    output fetch_fault
  );

  modport slave (
    output enable,
    input  mem_addr,
    output mem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc,
    output redirect_valid,
    output redirect_target,
    input  fetch_fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Purpose: reads PC..PC+3 from a byte-wide big-endian memory, assembles a 32-bit word, owns the PC.
// Latency: word valid 4 cycles after fetch starts (5 after reset release); 1 word per 5 cycles.
// Backpressure: word, PC and mem_addr held while instr_ready=0; optional FETCH_BOUNDS_CHECK_EN adds FAULT.
module fetch_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int RESET_PC  = 0,
  parameter int MEM_BYTES = 64
) (
  input logic               clk,
  input logic               reset,
  fetch_sequencer_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] VALID = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  // A memory smaller than one instruction cannot hold a program.
  if (MEM_BYTES < 4) begin : g_bad_mem_bytes
    $error("fetch_sequencer: MEM_BYTES must be at least 4");
  end

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        byte_cnt;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              accept;
  logic [ADDR_W-1:0] redirect_pc;
  logic [4:0]        lane_lsb;

  // Byte lane 0 lands in the most significant byte (big-endian).
  assign lane_lsb    = {~byte_cnt, 3'b000};
  assign accept      = instr_valid && bus.instr_ready;
  assign redirect_pc = {bus.redirect_target[ADDR_W-1:2], 2'b00};

  assign bus.mem_addr    = pc + ADDR_W'(byte_cnt);
  assign bus.instr_valid = instr_valid;
  assign bus.instr       = instr;
  assign bus.instr_pc    = instr_pc;

`ifdef FETCH_BOUNDS_CHECK_EN
  logic          fault;
  logic [ADDR_W:0] pc_last;
  logic          out_of_range;

  // One extra bit so a PC near the top of the address space cannot wrap past the limit.
  assign pc_last       = {1'b0, pc} + (ADDR_W+1)'(3);
  assign out_of_range  = pc_last >= (ADDR_W+1)'(MEM_BYTES);
  assign bus.fetch_fault = fault;
`else
  assign bus.fetch_fault = 1'b0;
`endif

  // Sequencer state: reset beats redirect, redirect beats accept, everything else needs enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= ADDR_W'(RESET_PC);
      byte_cnt    <= 2'd0;
      instr_valid <= 1'b0;
      instr       <= 32'd0;
      instr_pc    <= ADDR_W'(RESET_PC);
`ifdef FETCH_BOUNDS_CHECK_EN
      fault       <= 1'b0;
`endif
    end else if (bus.redirect_valid) begin
      // Pending or partial word is dropped; an accept in this cycle still went to IF/ID.
      pc          <= redirect_pc;
      byte_cnt    <= 2'd0;
      instr_valid <= 1'b0;
      state       <= bus.enable ? FETCH : IDLE;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault       <= 1'b0;
`endif
    end else if (accept) begin
      // Accept completes even while stalled; the next fetch then waits for enable.
      instr_valid <= 1'b0;
      pc          <= pc + ADDR_W'(4);
      byte_cnt    <= 2'd0;
      state       <= FETCH;
    end else if (bus.enable) begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
`ifdef FETCH_BOUNDS_CHECK_EN
          if (byte_cnt == 2'd0 && out_of_range) begin
            state <= FAULT;
            fault <= 1'b1;
          end else begin
`else
          begin
`endif
            instr[lane_lsb +: 8] <= bus.mem_rdata;
            byte_cnt             <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state       <= VALID;
              instr_valid <= 1'b1;
              instr_pc    <= pc;
            end
          end
        end
        VALID: begin
          state <= VALID;
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
